ptr_gen: RTL and testbench

PTR_GEN -- requirements
Module: ptr_gen

---
 rtl/ptr_gen.sv | 104 ++++++++++
 tb/tb_ptr_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ptr_gen.sv
// FIFO pointer generator for one clock domain: local binary/Gray pointer,
// remote-pointer synchroniser, occupancy estimate and almost flag.
module ptr_gen #(
  parameter int STATE       = 0,
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int THRESH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  blocked,
  input  logic [ADDR_WIDTH:0]   ptr_rmt_async,
  output logic                  accept,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH:0]   ptr_gray,
  output logic [ADDR_WIDTH:0]   ptr_rmt_sync,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost,
  output logic                  err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_MARK  = (ADDR_WIDTH+1)'(DEPTH - THRESH);
  localparam logic [ADDR_WIDTH:0] EMPTY_MARK = (ADDR_WIDTH+1)'(THRESH);

  function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
    logic [ADDR_WIDTH:0] b;
    b[ADDR_WIDTH] = g[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDR_WIDTH:0] bin_q, bin_d;
  logic [ADDR_WIDTH:0] gray_q, gray_d;
  logic [ADDR_WIDTH:0] sync_q [SYNC_STAGES];
  logic [ADDR_WIDTH:0] sync_d [SYNC_STAGES];
  logic [ADDR_WIDTH:0] level_q, level_d;
  logic                almost_q, almost_d;
  logic                err_q, err_d;
  logic [ADDR_WIDTH:0] rbin;

  // Stage: local pointer advance and remote pointer synchroniser inputs
  always_comb begin
    accept = inc & ~blocked;
    bin_d  = bin_q;
    if (accept) begin
      bin_d = bin_q + (ADDR_WIDTH+1)'(1);
    end
    // Gray is derived from the next binary value so it is glitch-free at the flop output
    gray_d = bin_d ^ (bin_d >> 1);
    err_d  = err_q | (inc & blocked);
    sync_d[0] = ptr_rmt_async;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Stage: occupancy estimate from the registered local and synchronised remote pointers
  always_comb begin
    rbin     = gray2bin(sync_q[SYNC_STAGES-1]);
    level_d  = '0;
    almost_d = 1'b0;
    if (STATE == 1) begin
      level_d  = bin_q - rbin;
      almost_d = (level_d >= FULL_MARK);
    end else begin
      level_d  = rbin - bin_q;
      almost_d = (level_d <= EMPTY_MARK);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q    <= '0;
      gray_q   <= '0;
      level_q  <= '0;
      almost_q <= (STATE == 0);
      err_q    <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      bin_q    <= bin_d;
      gray_q   <= gray_d;
      level_q  <= level_d;
      almost_q <= almost_d;
      err_q    <= err_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign addr         = bin_q[ADDR_WIDTH-1:0];
  assign ptr_gray     = gray_q;
  assign ptr_rmt_sync = sync_q[SYNC_STAGES-1];
  assign level        = level_q;
  assign almost       = almost_q;
  assign err          = err_q;

endmodule

// File: tb/tb_ptr_gen.sv
// Bench for ptr_gen: one read-side and one write-side instance run against
// a modular-arithmetic occupancy model, plus literal checks of key scenarios.
module tb_ptr_gen;

  localparam int AW   = 4;
  localparam int SYNC = 2;
  localparam int TH   = 2;
  localparam int MOD  = 1 << (AW + 1);
  localparam int DEP  = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          inc_a  [2];
  logic          blk_a  [2];
  logic [AW:0]   rmt_a  [2];
  logic          acc_a  [2];
  logic [AW-1:0] addr_a [2];
  logic [AW:0]   gray_a [2];
  logic [AW:0]   sync_a [2];
  logic [AW:0]   lvl_a  [2];
  logic          alm_a  [2];
  logic          err_a  [2];

  ptr_gen #(.STATE(0), .ADDR_WIDTH(AW), .SYNC_STAGES(SYNC), .THRESH(TH)) u_rd (
    .clk(clk), .rst(rst), .inc(inc_a[0]), .blocked(blk_a[0]),
    .ptr_rmt_async(rmt_a[0]), .accept(acc_a[0]), .addr(addr_a[0]),
    .ptr_gray(gray_a[0]), .ptr_rmt_sync(sync_a[0]), .level(lvl_a[0]),
    .almost(alm_a[0]), .err(err_a[0]));

  ptr_gen #(.STATE(1), .ADDR_WIDTH(AW), .SYNC_STAGES(SYNC), .THRESH(TH)) u_wr (
    .clk(clk), .rst(rst), .inc(inc_a[1]), .blocked(blk_a[1]),
    .ptr_rmt_async(rmt_a[1]), .accept(acc_a[1]), .addr(addr_a[1]),
    .ptr_gray(gray_a[1]), .ptr_rmt_sync(sync_a[1]), .level(lvl_a[1]),
    .almost(alm_a[1]), .err(err_a[1]));

  int tests = 0;
  int fails = 0;

  // Model: count of accepts, history of sampled remote pointers, derived level.
  int m_cnt   [2];
  int m_hist  [2][SYNC];
  int m_level [2];
  int m_alm   [2];
  int m_err   [2];
  int gtab    [MOD];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_cnt[s] = 0;
      m_level[s] = 0;
      m_alm[s] = (s == 0) ? 1 : 0;
      m_err[s] = 0;
      for (int k = 0; k < SYNC; k++) m_hist[s][k] = 0;
    end
  endtask

  task automatic model_edge(int s);
    int rb, lv;
    if (rst) begin
      m_cnt[s] = 0;
      m_level[s] = 0;
      m_alm[s] = (s == 0) ? 1 : 0;
      m_err[s] = 0;
      for (int k = 0; k < SYNC; k++) m_hist[s][k] = 0;
      return;
    end
    rb = gtab[m_hist[s][SYNC-1]];
    lv = (s == 1) ? (m_cnt[s] - rb + MOD) % MOD : (rb - m_cnt[s] + MOD) % MOD;
    m_level[s] = lv;
    m_alm[s] = (s == 1) ? int'(lv >= DEP - TH) : int'(lv <= TH);
    if (inc_a[s] && blk_a[s]) m_err[s] = 1;
    if (inc_a[s] && !blk_a[s]) m_cnt[s] = (m_cnt[s] + 1) % MOD;
    for (int k = SYNC - 1; k > 0; k--) m_hist[s][k] = m_hist[s][k-1];
    m_hist[s][0] = int'(rmt_a[s]);
  endtask

  task automatic compare_all(int s);
    string p;
    p = (s == 0) ? "rd" : "wr";
    chk({p, ".accept"}, acc_a[s], inc_a[s] & ~blk_a[s]);
    chk({p, ".addr"},   addr_a[s], m_cnt[s] % DEP);
    chk({p, ".gray"},   gray_a[s], m_cnt[s] ^ (m_cnt[s] >> 1));
    chk({p, ".sync"},   sync_a[s], m_hist[s][SYNC-1]);
    chk({p, ".level"},  lvl_a[s], m_level[s]);
    chk({p, ".almost"}, alm_a[s], m_alm[s]);
    chk({p, ".err"},    err_a[s], m_err[s]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    compare_all(0);
    compare_all(1);
  endtask

  task automatic clear_inputs();
    for (int s = 0; s < 2; s++) begin
      inc_a[s] = 1'b0;
      blk_a[s] = 1'b0;
      rmt_a[s] = '0;
    end
  endtask

  task automatic reset_pulse();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [AW:0] prev;
    for (int i = 0; i < MOD; i++) gtab[(i ^ (i >> 1)) % MOD] = i;
    clear_inputs();
    model_reset();
    @(negedge clk);
    compare_all(0);
    compare_all(1);
    chk("reset.rd.almost", alm_a[0], 1);
    chk("reset.wr.almost", alm_a[1], 0);
    chk("reset.rd.level", lvl_a[0], 0);
    rst = 1'b0;

    // Write side pushes 5 while read side sees remote Gray 00011 (binary 2)
    inc_a[1] = 1'b1;
    rmt_a[0] = 5'b00011;
    tick();
    tick();
    chk("rd.sync_lat2", sync_a[0], 5'b00011);
    tick();
    chk("rd.level2", lvl_a[0], 2);
    chk("rd.almost_at2", alm_a[0], 1);
    tick();
    tick();
    chk("wr.addr5", addr_a[1], 5);
    chk("wr.gray5", gray_a[1], 5'b00111);
    inc_a[1] = 1'b0;
    rmt_a[0] = 5'b00010;
    tick();
    chk("wr.level5", lvl_a[1], 5);
    chk("wr.almost5", alm_a[1], 0);
    tick();
    tick();
    tick();
    chk("rd.level3", lvl_a[0], 3);
    chk("rd.almost_at3", alm_a[0], 0);

    // Push while blocked
    inc_a[1] = 1'b1;
    blk_a[1] = 1'b1;
    #1;
    chk("wr.blocked_accept", acc_a[1], 0);
    tick();
    chk("wr.blocked_addr", addr_a[1], 5);
    chk("wr.err_set", err_a[1], 1);
    inc_a[1] = 1'b0;
    blk_a[1] = 1'b0;
    tick();
    chk("wr.err_sticky", err_a[1], 1);

    // Fill to 14, then asynchronous reset mid-cycle
    reset_pulse();
    inc_a[1] = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    inc_a[1] = 1'b0;
    tick();
    chk("wr.level14", lvl_a[1], 14);
    chk("wr.almost14", alm_a[1], 1);
    #2 rst = 1'b1;
    #1;
    chk("arst.addr", addr_a[1], 0);
    chk("arst.gray", gray_a[1], 0);
    chk("arst.level", lvl_a[1], 0);
    chk("arst.almost", alm_a[1], 0);
    chk("arst.sync", sync_a[1], 0);
    chk("arst.err", err_a[1], 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    compare_all(0);
    compare_all(1);
    chk("rd.release_almost", alm_a[0], 1);
    chk("rd.release_level", lvl_a[0], 0);
    inc_a[0] = 1'b1;
    blk_a[0] = 1'b1;
    tick();
    chk("rd.err_set", err_a[0], 1);
    chk("rd.blocked_addr", addr_a[0], 0);
    chk("rd.blocked_gray", gray_a[0], 0);

    // Full pointer wrap with one-bit Gray steps
    reset_pulse();
    inc_a[1] = 1'b1;
    prev = gray_a[1];
    for (int i = 0; i < MOD; i++) begin
      tick();
      chk("wr.gray_onebit", $countones(prev ^ gray_a[1]), 1);
      if (i == DEP - 1) chk("wr.addr_wrap16", addr_a[1], 0);
      prev = gray_a[1];
    end
    chk("wr.gray_wrap32", gray_a[1], 0);
    chk("wr.addr_wrap32", addr_a[1], 0);
    inc_a[1] = 1'b0;

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int s = 0; s < 2; s++) begin
        inc_a[s] = ($urandom_range(0, 9) < 7);
        blk_a[s] = ($urandom_range(0, 9) < 2);
        rmt_a[s] = (AW+1)'($urandom);
      end
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
